cd_config_arbiter: RTL
======================

Name: cd_config_arbiter

Overview:
Shares the Clock_Divider configuration port (c_addr/c_data/c_valid/c_ready) between NUM_REQ requesters, e.g. the UART command parser and the VGA menu logic. Round-robin grant. Each transaction is sequenced through the divider's ready handshake, with a timeout. Each requester receives a one-cycle done or error pulse.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
WIDTH_CONFIG_ADDR, 2, config address width (01 = UART, 10 = VGA)
WIDTH_CONFIG_DATA, 4, config data width
SYNC_STAGES, 2, flops in the c_ready synchronizer (c_ready comes from the configuration clock domain)
TIMEOUT_CYCLES, 1023, max cycles spent in WAIT_ACC plus WAIT_DONE before error
WIDTH_TIMEOUT, 10, timeout counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level; hold until ack or err
req_addr  in  NUM_REQ*WIDTH_CONFIG_ADDR  packed addresses; requester i occupies slice i
req_data  in  NUM_REQ*WIDTH_CONFIG_DATA  packed data; requester i occupies slice i
ack  out  NUM_REQ  one-cycle pulse: transaction completed
err  out  NUM_REQ  one-cycle pulse: illegal address or timeout
c_addr  out  WIDTH_CONFIG_ADDR  to divider
c_data  out  WIDTH_CONFIG_DATA  to divider
c_valid  out  1  to divider
c_ready  in  1  from divider; 1 = busy reconfiguring, 0 = free
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; ack, err, c_valid, c_addr, c_data = 0; busy = 0; rr pointer = 0; timeout counter = 0; synchronizer flops = 0.
- c_ready passes through SYNC_STAGES flops before use; rdy_s is the synchronized value.
- IDLE:
  - If any req is high, grant the first requester at or after rr pointer (round-robin), latch its addr/data, and go to CHECK.
  - rr pointer becomes grant+1, wrapping modulo NUM_REQ.
- CHECK (1 cycle):
  - Address not 01 and not 10: go to RESP with error flag set.
  - Otherwise: go to WAIT_ACC, drive c_addr/c_data from the latch, assert c_valid.
- WAIT_ACC:
  - Hold c_valid, c_addr and c_data stable.
  - When rdy_s = 1: deassert c_valid next cycle and go to WAIT_DONE.
- WAIT_DONE: when rdy_s = 0, go to RESP with error flag clear.
- Timeout:
  - The counter is cleared on entry to WAIT_ACC and increments in WAIT_ACC and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: drop c_valid, go to RESP with error flag set.
- RESP (1 cycle):
  - Pulse ack[grant] if no error, else err[grant].
  - Never both. Only the granted bit is ever set.
  - Return to IDLE.
- Arbitration is decided only in IDLE. A req arriving mid-transaction waits. A granted req dropped early is ignored; the transaction still completes and responds.
- A requester whose req stays high after its ack is re-eligible. Round-robin guarantees the other requester is served first if it is pending.
- c_addr/c_data return to 0 whenever c_valid = 0.
- Minimum latency, req high to ack pulse, with SYNC_STAGES = 2 and the divider asserting ready the cycle after c_valid:
  - 1 cycle: grant.
  - 1 cycle: CHECK.
  - 3 cycles: ready synchronization.
  - 3 cycles: ready deassert plus synchronization.
  - 1 cycle: RESP.
  - Total: about 9 cycles. The bench checks ordering, not an exact count, beyond the illegal-address path.
- Illegal-address path is exact: ack/err pulse in the 3rd cycle after req is sampled (IDLE -> CHECK -> RESP).
- rst asserted mid-transaction: immediate return to reset values. No ack/err is produced for the aborted request.

Decomposition:
- Shared package: state encoding (IDLE, CHECK, WAIT_ACC, WAIT_DONE, RESP), the address constants CFG_ADDR_UART = 2'b01 and CFG_ADDR_VGA = 2'b10, and default widths (kept consistent with CD_params).
- Sub-module rr_arbiter: NUM_REQ requests + pointer in, one-hot grant + index out. Purely combinational; the pointer register stays in the parent.
- The synchronizer is inline flops.

Test Plan:
1. Reset, then req[0] with addr 01, data 4'h5; divider model raises c_ready 2 cycles after c_valid and holds it 4 cycles -> c_addr = 01, c_data = 5 while c_valid is high; exactly one ack[0] pulse; err = 0; busy low afterwards.
2. req[1] with addr 11 -> no c_valid ever asserted; err[1] pulses in the 3rd cycle after sampling; ack stays 0.
3. req[0] and req[1] both high at once after reset -> requester 0 is served first, then requester 1. A second simultaneous burst serves requester 0 first (pointer points to requester 0). Grants alternate under sustained requests.
4. Divider model never raises c_ready -> c_valid held until timeout, then dropped; err[0] pulses at WAIT_ACC entry + 1023 cycles + 1; FSM back in IDLE.
5. c_ready stuck at 1 after acceptance -> timeout from WAIT_DONE gives err pulse; next request is still serviced normally.
6. rst pulled low during WAIT_DONE -> all outputs 0 asynchronously (before the next clk edge); no ack/err after release; a fresh request then completes with ack.

Source files
------------

// File: rtl/cd_config_arbiter_pkg.sv
// Shared types and constants for the clock-divider configuration arbiter.
package cd_config_arbiter_pkg;

  localparam int DEF_NUM_REQ           = 2;
  localparam int DEF_WIDTH_CONFIG_ADDR = 2;
  localparam int DEF_WIDTH_CONFIG_DATA = 4;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_TIMEOUT_CYCLES    = 1023;
  localparam int DEF_WIDTH_TIMEOUT     = 10;

  // Only these two divider targets exist; anything else is rejected.
  localparam logic [1:0] CFG_ADDR_UART = 2'b01;
  localparam logic [1:0] CFG_ADDR_VGA  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_ACC,
    ST_WAIT_DONE,
    ST_RESP
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cd_config_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Scan from the pointer, wrapping, and keep the first hit.
  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (gnt == '0 && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cd_config_arbiter.sv
// Round-robin sharing of the clock-divider config port with ready handshake,
// timeout and one-cycle ack/err pulses back to the granted requester.
module cd_config_arbiter
  import cd_config_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = DEF_NUM_REQ,
  parameter int WIDTH_CONFIG_ADDR = DEF_WIDTH_CONFIG_ADDR,
  parameter int WIDTH_CONFIG_DATA = DEF_WIDTH_CONFIG_DATA,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
  parameter int WIDTH_TIMEOUT     = DEF_WIDTH_TIMEOUT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*WIDTH_CONFIG_ADDR-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH_CONFIG_DATA-1:0] req_data,
  output logic [NUM_REQ-1:0]                   ack,
  output logic [NUM_REQ-1:0]                   err,
  output logic [WIDTH_CONFIG_ADDR-1:0]         c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0]         c_data,
  output logic                                 c_valid,
  input  logic                                 c_ready,
  output logic                                 busy
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [WIDTH_CONFIG_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH_CONFIG_DATA-1:0] data_q, data_d;
  logic [WIDTH_TIMEOUT-1:0]     tmo_q, tmo_d;
  logic                         err_flag_q, err_flag_d;
  logic [SYNC_STAGES-1:0]       sync_q, sync_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               rdy_s;
  logic               addr_ok;
  logic               tmo_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign rdy_s   = sync_q[SYNC_STAGES-1];
  assign addr_ok = (addr_q == WIDTH_CONFIG_ADDR'(CFG_ADDR_UART)) ||
                   (addr_q == WIDTH_CONFIG_ADDR'(CFG_ADDR_VGA));
  assign tmo_hit = (tmo_q == WIDTH_TIMEOUT'(TIMEOUT_CYCLES));

  // c_ready crosses from the config clock domain: plain shift chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = c_ready;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // All state flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      err_flag_q <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      err_flag_q <= err_flag_d;
      sync_q     <= sync_d;
    end
  end

  // Next state: arbitrate in IDLE only, then sequence the divider handshake.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    err_flag_d = err_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_d    = ST_CHECK;
          gnt_idx_d  = arb_idx;
          addr_d     = req_addr[int'(arb_idx)*WIDTH_CONFIG_ADDR +: WIDTH_CONFIG_ADDR];
          data_d     = req_data[int'(arb_idx)*WIDTH_CONFIG_DATA +: WIDTH_CONFIG_DATA];
          err_flag_d = 1'b0;
          rr_ptr_d   = (int'(arb_idx) == NUM_REQ-1) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_CHECK: begin
        if (addr_ok) begin
          state_d = ST_WAIT_ACC;
          tmo_d   = '0;
        end else begin
          state_d    = ST_RESP;
          err_flag_d = 1'b1;
        end
      end
      ST_WAIT_ACC: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
          state_d    = ST_RESP;
          err_flag_d = 1'b1;
        end else if (rdy_s) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
          state_d    = ST_RESP;
          err_flag_d = 1'b1;
        end else if (!rdy_s) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registered state; bus is zero unless valid.
  always_comb begin
    ack     = '0;
    err     = '0;
    busy    = (state_q != ST_IDLE);
    c_valid = (state_q == ST_WAIT_ACC);
    c_addr  = c_valid ? addr_q : '0;
    c_data  = c_valid ? data_q : '0;
    if (state_q == ST_RESP) begin
      if (err_flag_q) err[gnt_idx_q] = 1'b1;
      else            ack[gnt_idx_q] = 1'b1;
    end
  end

endmodule
